// File: rtl/zoom_sequencer_if.sv
// Handshake bundle between the user-input layer, the scaling datapath and zoom_sequencer.
// The master side drives buttons, switch faults and done; the slave side is the sequencer.
interface zoom_sequencer_if #(
  parameter int unsigned LEVEL_W = 3,
  parameter int unsigned ALG_W   = 2
);
  logic               zoom_in;
  logic               zoom_out;
  logic [ALG_W-1:0]   algorithm_select;
  logic               multiple_switches_error;
  logic               no_switch_selected_error;
  logic               done;
  logic               enable;
  logic               wren;
  logic [LEVEL_W-1:0] zoom_level;
  logic [LEVEL_W-1:0] target_level;
  logic [ALG_W-1:0]   active_alg;
  logic               busy;
  logic               pending;
  logic               invalid_zoom_error;
  logic               limit_error;
  logic               timeout_error;
  logic               overrun_error;

  modport master (
    output zoom_in, zoom_out, algorithm_select, multiple_switches_error,
           no_switch_selected_error, done,
    input  enable, wren, zoom_level, target_level, active_alg, busy, pending,
           invalid_zoom_error, limit_error, timeout_error, overrun_error
  );

  modport slave (
    input  zoom_in, zoom_out, algorithm_select, multiple_switches_error,
           no_switch_selected_error, done,
    output enable, wren, zoom_level, target_level, active_alg, busy, pending,
           invalid_zoom_error, limit_error, timeout_error, overrun_error
  );
endinterface

// File: rtl/zoom_sequencer.sv
// Zoom job sequencer: edge-detects zoom buttons, buffers one pending request, runs each job
// through PROCESS/WRITE under a watchdog, and commits the level only after the write.
module zoom_sequencer #(
  parameter int unsigned LEVELS      = 5,
  parameter int unsigned LEVEL_W     = 3,
  parameter int unsigned RESET_LEVEL = 2,
  parameter int unsigned ALG_W       = 2,
  parameter int unsigned TIMEOUT     = 1024,
  parameter int unsigned TO_W        = 10
) (
  input  logic           clk,
  input  logic           reset,
  zoom_sequencer_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StProcess, StWrite} state_e;

  localparam logic [LEVEL_W-1:0] MaxLevel   = LEVEL_W'(LEVELS - 1);
  localparam logic [LEVEL_W-1:0] ResetLevel = LEVEL_W'(RESET_LEVEL);
  localparam logic [TO_W-1:0]    WdLast     = TO_W'(TIMEOUT - 1);

  state_e             state_q;
  logic               zin_q, zout_q;
  logic [TO_W-1:0]    wd_q;
  logic [LEVEL_W-1:0] zoom_level_q, target_q;
  logic [ALG_W-1:0]   active_alg_q;
  logic               pend_q, pend_dir_q;
  logic [ALG_W-1:0]   pend_alg_q;
  logic               inv_err_q, limit_q, timeout_q, overrun_q;

  logic               rise_in, rise_out, one_rise;
  logic               req_valid, req_invalid, req_dir;
  logic [ALG_W-1:0]   req_alg;
  logic               launch_req, launch_dir, launch_ok;
  logic [ALG_W-1:0]   launch_alg;

  always_comb begin
    rise_in     = bus.zoom_in & ~zin_q;
    rise_out    = bus.zoom_out & ~zout_q;
    one_rise    = ~(bus.multiple_switches_error | bus.no_switch_selected_error) &
                  (rise_in ^ rise_out);
    req_dir     = rise_in;  // 1 = zoom in
    req_alg     = bus.algorithm_select;
    // Zoom-in pairs with MSB=0, zoom-out with MSB=1.
    req_valid   = one_rise & (rise_in ^ req_alg[ALG_W-1]);
    req_invalid = one_rise & ~req_valid;

    // The pending entry always launches ahead of a fresh request.
    launch_req  = pend_q | req_valid;
    launch_dir  = pend_q ? pend_dir_q : req_dir;
    launch_alg  = pend_q ? pend_alg_q : req_alg;
    launch_ok   = launch_dir ? (zoom_level_q < MaxLevel) : (zoom_level_q != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      zin_q        <= 1'b0;
      zout_q       <= 1'b0;
      wd_q         <= '0;
      zoom_level_q <= ResetLevel;
      target_q     <= ResetLevel;
      active_alg_q <= '0;
      pend_q       <= 1'b0;
      pend_dir_q   <= 1'b0;
      pend_alg_q   <= '0;
      inv_err_q    <= 1'b0;
      limit_q      <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      zin_q     <= bus.zoom_in;
      zout_q    <= bus.zoom_out;
      limit_q   <= 1'b0;
      timeout_q <= 1'b0;
      overrun_q <= 1'b0;

      if (req_valid) begin
        inv_err_q <= 1'b0;
      end else if (req_invalid) begin
        inv_err_q <= 1'b1;
      end

      case (state_q)
        StIdle: begin
          if (launch_req) begin
            // A launched pending entry is replaced by a simultaneous new request.
            pend_q <= pend_q & req_valid;
            if (pend_q && req_valid) begin
              pend_dir_q <= req_dir;
              pend_alg_q <= req_alg;
            end
            if (launch_ok) begin
              target_q     <= launch_dir ? zoom_level_q + LEVEL_W'(1)
                                         : zoom_level_q - LEVEL_W'(1);
              active_alg_q <= launch_alg;
              wd_q         <= '0;
              state_q      <= StProcess;
            end else begin
              limit_q <= 1'b1;
            end
          end
        end
        StProcess: begin
          if (bus.done) begin
            state_q <= StWrite;
          end else if (wd_q == WdLast) begin
            state_q   <= StIdle;
            timeout_q <= 1'b1;
            target_q  <= zoom_level_q;
          end else begin
            wd_q <= wd_q + TO_W'(1);
          end
        end
        StWrite: begin
          zoom_level_q <= target_q;
          state_q      <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (state_q != StIdle && req_valid) begin
        if (pend_q) begin
          overrun_q <= 1'b1;
        end else begin
          pend_q     <= 1'b1;
          pend_dir_q <= req_dir;
          pend_alg_q <= req_alg;
        end
      end
    end
  end

  assign bus.enable             = (state_q == StProcess);
  assign bus.wren               = (state_q == StWrite);
  assign bus.busy               = (state_q != StIdle);
  assign bus.zoom_level         = zoom_level_q;
  assign bus.target_level       = target_q;
  assign bus.active_alg         = active_alg_q;
  assign bus.pending            = pend_q;
  assign bus.invalid_zoom_error = inv_err_q;
  assign bus.limit_error        = limit_q;
  assign bus.timeout_error      = timeout_q;
  assign bus.overrun_error      = overrun_q;

endmodule

// File: tb/tb_zoom_sequencer.sv
// Randomized scoreboard bench for zoom_sequencer: expected events are queued by the driver
// from a level/flag model and consumed by a monitor watching wren and the error pulses.
module tb_zoom_sequencer;
  localparam int unsigned LEVELS      = 5;
  localparam int unsigned LEVEL_W     = 3;
  localparam int unsigned RESET_LEVEL = 2;
  localparam int unsigned ALG_W       = 2;
  localparam int unsigned TIMEOUT     = 8;
  localparam int unsigned TO_W        = 3;

  logic clk = 1'b0;
  logic reset;

  zoom_sequencer_if #(.LEVEL_W(LEVEL_W), .ALG_W(ALG_W)) bus ();

  zoom_sequencer #(
    .LEVELS(LEVELS), .LEVEL_W(LEVEL_W), .RESET_LEVEL(RESET_LEVEL),
    .ALG_W(ALG_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef enum int {EvJob, EvLimit, EvTimeout, EvOverrun} ev_kind_e;
  typedef struct {
    ev_kind_e kind;
    int       level;
    int       alg;
  } ev_t;

  ev_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  m_level;
  bit  m_inv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_ev(input ev_kind_e k, input int lvl, input int alg);
    ev_t e;
    e.kind  = k;
    e.level = lvl;
    e.alg   = alg;
    exp_q.push_back(e);
  endtask

  task automatic observe(input ev_kind_e k, input int lvl, input int alg);
    ev_t e;
    if (exp_q.size() == 0) begin
      check("unexpected_event", k, 99);
    end else begin
      e = exp_q.pop_front();
      check("event_kind", k, e.kind);
      if (k == EvJob && e.kind == EvJob) begin
        check("job_level", lvl, e.level);
        check("job_alg", alg, e.alg);
      end
    end
  endtask

  // Monitor: every output event is matched against the scoreboard in order.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wren)          observe(EvJob, int'(bus.target_level), int'(bus.active_alg));
      if (bus.limit_error)   observe(EvLimit, 0, 0);
      if (bus.timeout_error) observe(EvTimeout, 0, 0);
      if (bus.overrun_error) observe(EvOverrun, 0, 0);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit is_valid(input bit dir_in, input logic [1:0] alg);
    return dir_in ^ alg[1];
  endfunction

  function automatic bit in_range(input bit dir_in, input int lvl);
    return dir_in ? (lvl < int'(LEVELS) - 1) : (lvl > 0);
  endfunction

  function automatic bit pick_dir(input int lvl);
    if (lvl == 0) return 1'b1;
    if (lvl == int'(LEVELS) - 1) return 1'b0;
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] valid_alg(input bit dir_in);
    logic [1:0] a;
    a[1] = ~dir_in;
    a[0] = 1'($urandom_range(0, 1));
    return a;
  endfunction

  task automatic press(input bit dir_in, input logic [1:0] alg);
    bus.algorithm_select = alg;
    if (dir_in) bus.zoom_in = 1'b1;
    else        bus.zoom_out = 1'b1;
    tick;
    bus.zoom_in  = 1'b0;
    bus.zoom_out = 1'b0;
  endtask

  // done_at: PROCESS cycle carrying done (1..TIMEOUT), 0 = never (watchdog abort).
  task automatic run_job(input bit dir_in, input logic [1:0] alg, input int done_at);
    int tgt;
    int cnt;
    if (!is_valid(dir_in, alg)) begin
      press(dir_in, alg);
      m_inv = 1'b1;
      check("invalid_flag", bus.invalid_zoom_error, 1);
      check("invalid_busy", bus.busy, 0);
      tick;
      return;
    end
    m_inv = 1'b0;
    if (!in_range(dir_in, m_level)) begin
      push_ev(EvLimit, 0, 0);
      press(dir_in, alg);
      check("limit_busy", bus.busy, 0);
      check("limit_level", bus.zoom_level, m_level);
      check("limit_inv_clear", bus.invalid_zoom_error, 0);
      tick;
      return;
    end
    tgt = dir_in ? m_level + 1 : m_level - 1;
    if (done_at == 0) push_ev(EvTimeout, 0, 0);
    else              push_ev(EvJob, tgt, int'(alg));
    press(dir_in, alg);
    check("launch_enable", bus.enable, 1);
    check("launch_busy", bus.busy, 1);
    check("launch_inv_clear", bus.invalid_zoom_error, 0);
    if (done_at == 0) begin
      cnt = 0;
      while (bus.enable === 1'b1 && cnt < 50) begin
        cnt++;
        tick;
      end
      check("timeout_enable_cycles", cnt, TIMEOUT);
      check("timeout_busy", bus.busy, 0);
      check("timeout_level", bus.zoom_level, m_level);
      check("timeout_target", bus.target_level, m_level);
    end else begin
      repeat (done_at - 1) tick;
      bus.done = 1'b1;
      tick;
      bus.done = 1'b0;
      check("write_wren", bus.wren, 1);
      check("write_level_held", bus.zoom_level, m_level);
      tick;
      check("commit_level", bus.zoom_level, tgt);
      check("commit_busy", bus.busy, 0);
      m_level = tgt;
    end
    tick;
  endtask

  // Job A plus a buffered B and a dropped C during A's PROCESS.
  task automatic run_pending;
    bit         da, db, dc;
    logic [1:0] aa, ab, ac;
    int         ta, tb;
    bit         b_ok;
    da = pick_dir(m_level);
    aa = valid_alg(da);
    ta = da ? m_level + 1 : m_level - 1;
    db = 1'($urandom_range(0, 1));
    ab = valid_alg(db);
    dc = 1'($urandom_range(0, 1));
    ac = valid_alg(dc);
    b_ok = in_range(db, ta);
    tb = db ? ta + 1 : ta - 1;
    push_ev(EvOverrun, 0, 0);
    push_ev(EvJob, ta, int'(aa));
    if (b_ok) push_ev(EvJob, tb, int'(ab));
    else      push_ev(EvLimit, 0, 0);
    press(da, aa);
    check("pend_a_enable", bus.enable, 1);
    tick;
    press(db, ab);
    check("pend_set", bus.pending, 1);
    tick;
    press(dc, ac);
    check("pend_kept", bus.pending, 1);
    bus.done = 1'b1;
    tick;
    bus.done = 1'b0;
    tick;
    check("pend_commit_a", bus.zoom_level, ta);
    check("pend_idle_gap", bus.busy, 0);
    m_level = ta;
    tick;
    check("pend_drained", bus.pending, 0);
    check("pend_b_enable", bus.enable, b_ok);
    if (b_ok) begin
      bus.done = 1'b1;
      tick;
      bus.done = 1'b0;
      tick;
      check("pend_commit_b", bus.zoom_level, tb);
      m_level = tb;
    end
    m_inv = 1'b0;
    tick;
  endtask

  task automatic run_filter(input int variant);
    bit         d;
    logic [1:0] a;
    d = 1'($urandom_range(0, 1));
    a = 2'($urandom_range(0, 3));
    bus.algorithm_select = a;
    if (variant == 0) begin
      bus.zoom_in  = 1'b1;
      bus.zoom_out = 1'b1;
    end else begin
      if (variant == 1) bus.multiple_switches_error = 1'b1;
      else              bus.no_switch_selected_error = 1'b1;
      if (d) bus.zoom_in = 1'b1;
      else   bus.zoom_out = 1'b1;
    end
    tick;
    bus.zoom_in = 1'b0;
    bus.zoom_out = 1'b0;
    bus.multiple_switches_error = 1'b0;
    bus.no_switch_selected_error = 1'b0;
    check("filter_busy", bus.busy, 0);
    check("filter_pending", bus.pending, 0);
    check("filter_inv", bus.invalid_zoom_error, m_inv);
    check("filter_level", bus.zoom_level, m_level);
    tick;
  endtask

  task automatic run_held;
    bit         d;
    logic [1:0] a;
    int         tgt;
    d = pick_dir(m_level);
    a = valid_alg(d);
    tgt = d ? m_level + 1 : m_level - 1;
    push_ev(EvJob, tgt, int'(a));
    bus.algorithm_select = a;
    if (d) bus.zoom_in = 1'b1;
    else   bus.zoom_out = 1'b1;
    tick;
    check("held_launch", bus.enable, 1);
    tick;
    bus.done = 1'b1;
    tick;
    bus.done = 1'b0;
    repeat (17) tick;
    bus.zoom_in  = 1'b0;
    bus.zoom_out = 1'b0;
    check("held_idle", bus.busy, 0);
    check("held_level", bus.zoom_level, tgt);
    m_level = tgt;
    m_inv = 1'b0;
    tick;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_enable"}, bus.enable, 0);
    check({tag, "_wren"}, bus.wren, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_pending"}, bus.pending, 0);
    check({tag, "_level"}, bus.zoom_level, RESET_LEVEL);
    check({tag, "_target"}, bus.target_level, RESET_LEVEL);
    check({tag, "_alg"}, bus.active_alg, 0);
    check({tag, "_errors"}, {bus.invalid_zoom_error, bus.limit_error, bus.timeout_error,
                             bus.overrun_error}, 0);
  endtask

  initial begin
    int  kind;
    bit  d;
    reset = 1'b1;
    bus.zoom_in = 1'b0;
    bus.zoom_out = 1'b0;
    bus.algorithm_select = '0;
    bus.multiple_switches_error = 1'b0;
    bus.no_switch_selected_error = 1'b0;
    bus.done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0;
    m_level = RESET_LEVEL;
    m_inv = 1'b0;
    tick;

    // Directed: single zoom-in, upper limit, mismatch, timeout, done on last cycle.
    run_job(1'b1, 2'b00, 4);
    run_job(1'b1, 2'b00, 1);
    run_job(1'b1, 2'b01, 2);
    run_job(1'b1, 2'b00, 3);
    check("upper_level", bus.zoom_level, 4);
    run_job(1'b1, 2'b10, 1);
    run_job(1'b0, 2'b11, 2);
    run_job(1'b0, 2'b10, 0);
    run_job(1'b0, 2'b10, TIMEOUT);
    run_pending();
    run_filter(0);
    run_filter(1);
    run_filter(2);
    run_held();

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 4);
      d = 1'($urandom_range(0, 1));
      case (kind)
        0, 1: run_job(d, 2'($urandom_range(0, 3)), $urandom_range(1, TIMEOUT));
        2:    run_job(d, 2'($urandom_range(0, 3)), 0);
        3:    run_pending();
        default: run_filter($urandom_range(0, 2));
      endcase
    end
    run_held();
    check("queue_drained", exp_q.size(), 0);

    // Mid-job reset with a pending entry.
    d = pick_dir(m_level);
    press(d, valid_alg(d));
    tick;
    press(1'b1, 2'b00);
    check("midreset_pending", bus.pending, 1);
    #2;
    reset = 1'b1;
    #1;
    check_reset_state("midreset");
    tick;
    reset = 1'b0;
    m_level = RESET_LEVEL;
    m_inv = 1'b0;
    tick;
    check_reset_state("post_reset");
    run_job(1'b1, 2'b01, 2);
    repeat (3) tick;
    check("final_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

endmodule
